// File: rtl/key_svc_pkg.sv
// Shared state encoding and key PIO register map for the key interrupt servicer.
// KEY_SVC_LEVEL_READ_EN adds the key-level read states.
package key_svc_pkg;

`ifdef KEY_SVC_LEVEL_READ_EN
   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD_CAP,
      ST_RD_WAIT,
      ST_CLR,
      ST_LVL,
      ST_LVL_WAIT,
      ST_POST
   } svc_state_e;
`else
   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD_CAP,
      ST_RD_WAIT,
      ST_CLR,
      ST_POST
   } svc_state_e;
`endif

   localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
   localparam logic [1:0] KEY_ADDR_MASK = 2'd2;
   localparam logic [1:0] KEY_ADDR_CAP  = 2'd3;

endpackage

// File: rtl/key_svc_evt_reg.sv
// One-entry valid/ready holding register for captured key events.
module key_svc_evt_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_keys,
   input  logic             i_level_load,
   input  logic [WIDTH-1:0] i_level,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_keys,
   output logic [WIDTH-1:0] o_level
);

   logic             r_valid;
   logic [WIDTH-1:0] r_keys;
   logic [WIDTH-1:0] r_level;

   // A load only arrives while the register is empty, so it never races an accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_keys  <= '0;
         r_level <= '0;
      end else begin
         if (i_load) begin
            r_valid <= 1'b1;
            r_keys  <= i_keys;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
         if (i_level_load) begin
            r_level <= i_level;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_keys  = r_keys;
   assign o_level = r_level;

endmodule

// File: rtl/key_irq_servicer.sv
// Avalon-MM host servicing the edge-capture key PIO in place of a CPU ISR.
// Define KEY_SVC_LEVEL_READ_EN to also read the key levels after each clear.
module key_irq_servicer
   import key_svc_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] IRQ_MASK = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             irq,
   output logic [1:0]       avm_address,
   output logic             avm_chipselect,
   output logic             avm_write_n,
   output logic [31:0]      avm_writedata,
   input  logic [31:0]      avm_readdata,
   output logic [WIDTH-1:0] evt_keys,
   output logic [WIDTH-1:0] evt_level,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             busy
);

   svc_state_e       r_state;
   svc_state_e       w_next;
   logic             r_cs;
   logic             r_wr_n;
   logic [1:0]       r_addr;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_cap;
   logic             r_guard;
   logic             r_busy;
   logic             w_cs;
   logic             w_wr_n;
   logic [1:0]       w_addr;
   logic [WIDTH-1:0] w_wdata;
   logic             w_cap_load;
   logic             w_evt_load;
   logic             w_level_load;
   logic             w_unused_rdata;

   assign w_unused_rdata = ^avm_readdata[31:WIDTH];

   // Bus controls are decoded on the transition and registered, so each access is
   // on the bus while its state is current; the mask write lands in the first IDLE cycle.
   always_comb begin
      w_next       = r_state;
      w_cs         = 1'b0;
      w_wr_n       = 1'b1;
      w_addr       = KEY_ADDR_DATA;
      w_wdata      = '0;
      w_cap_load   = 1'b0;
      w_evt_load   = 1'b0;
      w_level_load = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_next  = ST_IDLE;
            w_cs    = 1'b1;
            w_wr_n  = 1'b0;
            w_addr  = KEY_ADDR_MASK;
            w_wdata = IRQ_MASK;
         end
         ST_IDLE: begin
            if (irq && !evt_valid && !r_guard) begin
               w_next = ST_RD_CAP;
               w_cs   = 1'b1;
               w_addr = KEY_ADDR_CAP;
            end
         end
         ST_RD_CAP: begin
            w_next = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            w_cap_load = 1'b1;
            w_next     = ST_CLR;
            w_cs       = 1'b1;
            w_wr_n     = 1'b0;
            w_addr     = KEY_ADDR_CAP;
         end
`ifdef KEY_SVC_LEVEL_READ_EN
         ST_CLR: begin
            w_next = ST_LVL;
            w_cs   = 1'b1;
            w_addr = KEY_ADDR_DATA;
         end
         ST_LVL: begin
            w_next = ST_LVL_WAIT;
         end
         ST_LVL_WAIT: begin
            w_level_load = 1'b1;
            w_next       = ST_POST;
         end
`else
         ST_CLR: begin
            w_next = ST_POST;
         end
`endif
         ST_POST: begin
            w_evt_load = (r_cap != '0);
            w_next     = ST_IDLE;
         end
         default: begin
            w_next = ST_INIT;
         end
      endcase
   end

   // The guard masks the stale irq that the slave still shows right after a clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_INIT;
         r_cs    <= 1'b0;
         r_wr_n  <= 1'b1;
         r_addr  <= KEY_ADDR_DATA;
         r_wdata <= '0;
         r_cap   <= '0;
         r_guard <= 1'b0;
         r_busy  <= 1'b1;
      end else begin
         r_state <= w_next;
         r_cs    <= w_cs;
         r_wr_n  <= w_wr_n;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         r_guard <= (r_state == ST_POST);
         r_busy  <= (w_next != ST_IDLE);
         if (w_cap_load) begin
            r_cap <= avm_readdata[WIDTH-1:0] & IRQ_MASK;
         end
      end
   end

   key_svc_evt_reg #(
      .WIDTH(WIDTH)
   ) u_evt_reg (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_load       (w_evt_load),
      .i_keys       (r_cap),
      .i_level_load (w_level_load),
      .i_level      (avm_readdata[WIDTH-1:0]),
      .i_ready      (evt_ready),
      .o_valid      (evt_valid),
      .o_keys       (evt_keys),
      .o_level      (evt_level)
   );

   assign avm_address    = r_addr;
   assign avm_chipselect = r_cs;
   assign avm_write_n    = r_wr_n;
   assign avm_writedata  = {{(32-WIDTH){1'b0}}, r_wdata};
   assign busy           = r_busy;

endmodule

// File: tb/tb_key_irq_servicer.sv
// Bench pairing key_irq_servicer with a behavioural falling-edge key PIO.
// Instance 0 uses the default mask, instance 1 uses IRQ_MASK=4'h1.
module tb_key_irq_servicer;

   localparam int W = 4;
`ifdef KEY_SVC_LEVEL_READ_EN
   localparam bit LEVEL_ON = 1'b1;
   localparam int LATENCY  = 7;
`else
   localparam bit LEVEL_ON = 1'b0;
   localparam int LATENCY  = 5;
`endif

   typedef struct {
      logic [W-1:0] press;
      logic [W-1:0] expKeys;
      logic [W-1:0] expLevel;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   nChecks = 0;
   int   nFails  = 0;

   logic [W-1:0] keys     [2];
   logic [W-1:0] pioD1    [2];
   logic [W-1:0] pioD2    [2];
   logic [W-1:0] pioCap   [2];
   logic [W-1:0] pioMask  [2];
   logic         pioIrq   [2];
   logic [31:0]  pioRdata [2];
   logic [1:0]   avmAddr  [2];
   logic         avmCs    [2];
   logic         avmWrn   [2];
   logic [31:0]  avmWdata [2];
   logic [W-1:0] evtKeys  [2];
   logic [W-1:0] evtLevel [2];
   logic         evtValid [2];
   logic         evtReady [2];
   logic         busy     [2];

   always #5 clk = ~clk;

   key_irq_servicer #(.WIDTH(W)) dutA (
      .clk(clk), .reset_n(reset_n), .irq(pioIrq[0]),
      .avm_address(avmAddr[0]), .avm_chipselect(avmCs[0]), .avm_write_n(avmWrn[0]),
      .avm_writedata(avmWdata[0]), .avm_readdata(pioRdata[0]),
      .evt_keys(evtKeys[0]), .evt_level(evtLevel[0]), .evt_valid(evtValid[0]),
      .evt_ready(evtReady[0]), .busy(busy[0])
   );

   key_irq_servicer #(.WIDTH(W), .IRQ_MASK(4'h1)) dutB (
      .clk(clk), .reset_n(reset_n), .irq(pioIrq[1]),
      .avm_address(avmAddr[1]), .avm_chipselect(avmCs[1]), .avm_write_n(avmWrn[1]),
      .avm_writedata(avmWdata[1]), .avm_readdata(pioRdata[1]),
      .evt_keys(evtKeys[1]), .evt_level(evtLevel[1]), .evt_valid(evtValid[1]),
      .evt_ready(evtReady[1]), .busy(busy[1])
   );

   // Key PIO model: two-stage synchroniser, falling-edge capture cleared by any
   // write to address 3, registered irq and read data with one cycle of latency.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            pioD1[i]    <= '0;
            pioD2[i]    <= '0;
            pioCap[i]   <= '0;
            pioMask[i]  <= '0;
            pioIrq[i]   <= 1'b0;
            pioRdata[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            pioD1[i]  <= keys[i];
            pioD2[i]  <= pioD1[i];
            pioIrq[i] <= |(pioCap[i] & pioMask[i]);
            if (avmCs[i] && !avmWrn[i] && avmAddr[i] == 2'd3)
               pioCap[i] <= '0;
            else
               pioCap[i] <= pioCap[i] | (pioD2[i] & ~pioD1[i]);
            if (avmCs[i] && !avmWrn[i] && avmAddr[i] == 2'd2)
               pioMask[i] <= avmWdata[i][W-1:0];
            case (avmAddr[i])
               2'd0:    pioRdata[i] <= {28'd0, pioD1[i]};
               2'd2:    pioRdata[i] <= {28'd0, pioMask[i]};
               2'd3:    pioRdata[i] <= {28'd0, pioCap[i]};
               default: pioRdata[i] <= '0;
            endcase
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [W-1:0] pattern);
      @(negedge clk);
      keys[idx] = pattern;
   endtask

   task automatic waitValidA(input int budget, output int cycles);
      cycles = 0;
      while (!evtValid[0] && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   function automatic logic [W-1:0] expLvl(input logic [W-1:0] p);
      return LEVEL_ON ? p : '0;
   endfunction

   vec_t vecs[4];
   int   cyc;
   bit   seen;

   initial begin
      vecs[0] = '{4'b1101, 4'b0010, expLvl(4'b1101)};
      vecs[1] = '{4'b1010, 4'b0101, expLvl(4'b1010)};
      vecs[2] = '{4'b0000, 4'b1111, expLvl(4'b0000)};
      vecs[3] = '{4'b0111, 4'b1000, expLvl(4'b0111)};

      reset_n     = 1'b0;
      keys[0]     = 4'hF;
      keys[1]     = 4'hF;
      evtReady[0] = 1'b1;
      evtReady[1] = 1'b1;
      repeat (3) @(negedge clk);

      // Reset values
      checkOutput("rst_cs", {31'd0, avmCs[0]}, 32'd0);
      checkOutput("rst_wrn", {31'd0, avmWrn[0]}, 32'd1);
      checkOutput("rst_addr", {30'd0, avmAddr[0]}, 32'd0);
      checkOutput("rst_wdata", avmWdata[0], 32'd0);
      checkOutput("rst_valid", {31'd0, evtValid[0]}, 32'd0);
      checkOutput("rst_keys", {28'd0, evtKeys[0]}, 32'd0);
      checkOutput("rst_level", {28'd0, evtLevel[0]}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy[0]}, 32'd1);

      // Init: single mask write, then idle bus
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("init_cs", {31'd0, avmCs[0]}, 32'd1);
      checkOutput("init_wrn", {31'd0, avmWrn[0]}, 32'd0);
      checkOutput("init_addr", {30'd0, avmAddr[0]}, 32'd2);
      checkOutput("init_wdata", avmWdata[0], 32'h0000000F);
      checkOutput("init_wdataB", avmWdata[1], 32'h00000001);
      @(negedge clk);
      checkOutput("init_idle_cs", {31'd0, avmCs[0]}, 32'd0);
      checkOutput("init_busy", {31'd0, busy[0]}, 32'd0);
      checkOutput("init_mask", {28'd0, pioMask[0]}, 32'hF);
      repeat (4) @(negedge clk);
      checkOutput("init_no_evt", {31'd0, evtValid[0]}, 32'd0);

      // Table-driven single presses with the consumer always ready
      for (int v = 0; v < 4; v++) begin
         keys[0] = vecs[v].press;
         seen = 1'b0;
         for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = pioIrq[0];
         end
         checkOutput($sformatf("v%0d_irq", v), {31'd0, seen}, 32'd1);
         waitValidA(20, cyc);
         checkOutput($sformatf("v%0d_latency", v), cyc, LATENCY);
         checkOutput($sformatf("v%0d_keys", v), {28'd0, evtKeys[0]}, {28'd0, vecs[v].expKeys});
         checkOutput($sformatf("v%0d_level", v), {28'd0, evtLevel[0]}, {28'd0, vecs[v].expLevel});
         checkOutput($sformatf("v%0d_cap_clr", v), {28'd0, pioCap[0]}, 32'd0);
         @(negedge clk);
         checkOutput($sformatf("v%0d_accept", v), {31'd0, evtValid[0]}, 32'd0);
         applyStimulus(0, 4'hF);
         repeat (6) @(negedge clk);
      end

      // Backpressure: second press waits in the slave until the first is accepted
      evtReady[0] = 1'b0;
      applyStimulus(0, 4'b1110);
      waitValidA(30, cyc);
      checkOutput("bp_first_keys", {28'd0, evtKeys[0]}, 32'b0001);
      applyStimulus(0, 4'b1010);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | busy[0] | avmCs[0];
      end
      checkOutput("bp_held_idle", {31'd0, seen}, 32'd0);
      checkOutput("bp_held_valid", {31'd0, evtValid[0]}, 32'd1);
      checkOutput("bp_held_keys", {28'd0, evtKeys[0]}, 32'b0001);
      checkOutput("bp_pending_cap", {28'd0, pioCap[0]}, 32'b0100);
      evtReady[0] = 1'b1;
      @(negedge clk);
      checkOutput("bp_first_accept", {31'd0, evtValid[0]}, 32'd0);
      waitValidA(20, cyc);
      checkOutput("bp_second_valid", {31'd0, evtValid[0]}, 32'd1);
      checkOutput("bp_second_keys", {28'd0, evtKeys[0]}, 32'b0100);
      applyStimulus(0, 4'hF);
      repeat (6) @(negedge clk);

      // Masked key on instance B: no irq, no bus traffic, no event
      applyStimulus(1, 4'b0111);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | pioIrq[1] | avmCs[1] | evtValid[1] | busy[1];
      end
      checkOutput("mask_quiet", {31'd0, seen}, 32'd0);
      keys[1] = 4'hF;

      // Reset during RD_WAIT
      applyStimulus(0, 4'b1011);
      seen = 1'b0;
      for (int t = 0; t < 30 && !seen; t++) begin
         @(negedge clk);
         seen = avmCs[0] && avmWrn[0] && (avmAddr[0] == 2'd3);
      end
      checkOutput("mr_rdcap_seen", {31'd0, seen}, 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("mr_cs", {31'd0, avmCs[0]}, 32'd0);
      checkOutput("mr_wrn", {31'd0, avmWrn[0]}, 32'd1);
      checkOutput("mr_addr", {30'd0, avmAddr[0]}, 32'd0);
      checkOutput("mr_busy", {31'd0, busy[0]}, 32'd1);
      checkOutput("mr_keys", {28'd0, evtKeys[0]}, 32'd0);
      checkOutput("mr_valid", {31'd0, evtValid[0]}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("mr_init_cs", {31'd0, avmCs[0]}, 32'd1);
      checkOutput("mr_init_addr", {30'd0, avmAddr[0]}, 32'd2);
      checkOutput("mr_init_wdata", avmWdata[0], 32'h0000000F);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | evtValid[0];
      end
      checkOutput("mr_no_stale", {31'd0, seen}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
